// File: rtl/swap_pkg.sv
// Shared definitions for the memory swap controller: FSM states, write-address
// mux select codes and the start-to-done latency.
package swap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_B = 3'd4,
        ST_DONE = 3'd5
    } swap_state_t;

    localparam logic [1:0] SEL_EXT  = 2'd0;
    localparam logic [1:0] SEL_ZERO = 2'd1;
    localparam logic [1:0] SEL_A    = 2'd2;
    localparam logic [1:0] SEL_B    = 2'd3;

    localparam int unsigned SWAP_LATENCY = 5;

endpackage

// File: rtl/swap_ctrl.sv
// Swap sequencer: read A, read B, write B->A, write A->B, then pulse done.
// Owns the memory ports during a swap; the external user gets them when idle.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | external pass-through, start accepted
// ST_RD_A | read address_A
// ST_RD_B | read address_B, capture A's data into tmp_a
// ST_WR_A | write B's data (bypassed from rd_data) to address_A
// ST_WR_B | write tmp_a to address_B
// ST_DONE | done pulse, external path still blocked
module swap_ctrl
    import swap_pkg::*;
#(
    parameter int addr_w_N    = 7,
    parameter int data_w_Bits = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [addr_w_N-1:0]    addr_a_in,
    input  logic [addr_w_N-1:0]    addr_b_in,
    input  logic                   ext_we,
    input  logic [data_w_Bits-1:0] ext_wdata,
    input  logic [addr_w_N-1:0]    ext_rd_addr,
    input  logic [data_w_Bits-1:0] rd_data,
    output logic [1:0]             sel,
    output logic [addr_w_N-1:0]    address_A,
    output logic [addr_w_N-1:0]    address_B,
    output logic [addr_w_N-1:0]    rd_addr,
    output logic                   mem_we,
    output logic [data_w_Bits-1:0] mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   ext_drop
);

    swap_state_t            state;
    swap_state_t            state_nxt;
    logic [data_w_Bits-1:0] tmp_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            address_A <= '0;
            address_B <= '0;
            tmp_a     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                address_A <= addr_a_in;
                address_B <= addr_b_in;
            end
            if (state == ST_RD_B) begin
                tmp_a <= rd_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel       = SEL_EXT;
        rd_addr   = address_A;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        ext_drop  = 1'b0;

        case (state)
            ST_IDLE: begin
                rd_addr   = ext_rd_addr;
                mem_we    = ext_we;
                mem_wdata = ext_wdata;
                if (start) begin
                    state_nxt = ST_RD_A;
                end
            end
            ST_RD_A: begin
                busy      = 1'b1;
                rd_addr   = address_A;
                state_nxt = ST_RD_B;
            end
            ST_RD_B: begin
                busy      = 1'b1;
                rd_addr   = address_B;
                state_nxt = ST_WR_A;
            end
            ST_WR_A: begin
                busy      = 1'b1;
                sel       = SEL_A;
                mem_we    = 1'b1;
                mem_wdata = rd_data;
                rd_addr   = address_B;
                state_nxt = ST_WR_B;
            end
            ST_WR_B: begin
                busy      = 1'b1;
                sel       = SEL_B;
                mem_we    = 1'b1;
                mem_wdata = tmp_a;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state != ST_IDLE) begin
            ext_drop = ext_we;
        end

        // Reset aborts at once: nothing may reach memory while rst is high.
        if (rst) begin
            sel       = SEL_EXT;
            rd_addr   = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
            busy      = 1'b0;
            done      = 1'b0;
            ext_drop  = 1'b0;
        end
    end

endmodule

// File: doc/swap_ctrl.md
# swap_ctrl

Sequencing controller for the memory swapper. On a start request it swaps the contents of two memory locations A and B with four memory cycles: read A, read B, write B's data to A, write A's data to B. It sits directly upstream of the write-address mux. It drives the mux select and the A/B addresses, and it arbitrates the memory write/read ports between the external user and the swap sequence.

## Interface
Parameters:
- addr_w_N, 7, address width
- data_w_Bits, 8, data width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  swap request, sampled in IDLE only
- addr_a_in  in  addr_w_N  location A, captured with start
- addr_b_in  in  addr_w_N  location B, captured with start
- ext_we  in  1  external write enable (pass-through when idle)
- ext_wdata  in  data_w_Bits  external write data
- ext_rd_addr  in  addr_w_N  external read address
- rd_data  in  data_w_Bits  memory read data, valid 1 cycle after rd_addr
- sel  out  2  write-address mux select: 0 external, 1 zero (never driven), 2 A, 3 B
- address_A  out  addr_w_N  registered A
- address_B  out  addr_w_N  registered B
- rd_addr  out  addr_w_N  memory read address
- mem_we  out  1  memory write enable
- mem_wdata  out  data_w_Bits  memory write data
- busy  out  1  high in RD_A..WR_B
- done  out  1  one-cycle pulse after WR_B
- ext_drop  out  1  ext_we asserted while busy (write discarded)

## Operation
- FSM states: IDLE, RD_A, RD_B, WR_A, WR_B, DONE. Binary encoding.
- IDLE: sel=0, rd_addr=ext_rd_addr, mem_we=ext_we, mem_wdata=ext_wdata. On start go to RD_A and latch address_A/address_B from addr_a_in/addr_b_in.
- RD_A: rd_addr=address_A, mem_we=0 → RD_B.
- RD_B: rd_addr=address_B, tmp_a <= rd_data (A's data) → WR_A.
- WR_A: sel=2, mem_we=1, mem_wdata=rd_data (B's data, bypassed), rd_addr=address_B → WR_B.
- WR_B: sel=3, mem_we=1, mem_wdata=tmp_a → DONE.
- DONE: done=1, sel=0, mem_we=0, external path still blocked → IDLE.
- address_A == address_B: full sequence runs. Memory is unchanged and done still pulses.
- start while not in IDLE: ignored, no queuing.
- ext_we in any state except IDLE: write dropped and ext_drop=1 in that cycle (combinational).
- sel=1 (zero address) is reserved for other masters and is never produced.

## Timing
- All memory-side outputs are combinational from state plus registers. address_A, address_B and tmp_a are registered.
- start sampled at edge N: RD_A in cycle N+1, RD_B N+2, WR_A N+3, WR_B N+4, done in N+5, IDLE (new start accepted) from N+6.
- Throughput: one swap per 6 cycles.
- Reset (rst high at an edge): state=IDLE, address_A=0, address_B=0, tmp_a=0. While rst is high: mem_we=0, sel=0, busy=0, done=0, ext_drop=0, mem_wdata=0, rd_addr=0.
- rst and start in the same cycle: reset wins and start is not captured.
- Reset mid-swap: abort immediately. A write already committed stays committed (partial swap is allowed); no further writes occur.
- rd_data is only sampled in RD_B and WR_A.

## Structure
- Shared package swap_pkg:
  - state enum/localparams (IDLE..DONE)
  - SEL_EXT=2'd0, SEL_ZERO=2'd1, SEL_A=2'd2, SEL_B=2'd3
  - SWAP_LATENCY=5
- Single module, no sub-module.
- The top level instantiates swap_ctrl, the write-address mux and the memory side by side.

## Test plan
- Reset then idle: after rst, memory [5]=0x11, [9]=0x22. Pulse start with A=5, B=9 → mem_we high in cycles N+3 (addr 5, data 0x22) and N+4 (addr 9, data 0x11); done at N+5; readback [5]=0x22, [9]=0x11.
- A==B=0x7F holding 0xAB → two writes of 0xAB to 0x7F, done at N+5, content still 0xAB.
- start re-asserted continuously during a swap → only one swap executes; second swap accepted at N+6.
- ext_we=1, ext_wdata=0x55 at N+2 → ext_drop=1, no write of 0x55; in IDLE the same request writes 0x55 with sel=0.
- rst asserted in WR_B cycle (N+4) → next cycle mem_we=0, busy=0, done never pulses; [A] holds B's data and [B] is unchanged.
- Back-to-back swaps (5,9) then (9,20) with 0x11/0x22/0x33 → final [5]=0x22, [9]=0x33, [20]=0x11.
